exc_sequencer: RTL and testbench
================================

EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_4180, exception/interrupt handler entry PC.
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of HWInt synchronizer (legal 2..3).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 exc_code_m  in  5  M-stage exception code; nonzero = internal exception present.
REQ-006 exc_bd_m  in  1  M-stage instruction sits in a branch delay slot.
REQ-007 eret_m  in  1  ERET at M stage.
REQ-008 hwint_raw  in  6  asynchronous external interrupt lines.
REQ-009 sr_ie, sr_exl  in  1 each  CP0 Status IE/EXL bits.
REQ-010 sr_im  in  6  CP0 Status IM[15:10].
REQ-011 epc  in  32  CP0 EPC value.
REQ-012 exc_occur  out  1  one-cycle pulse committing exception/interrupt to CP0.
REQ-013 exc_code  out  5  code to CP0 (interrupt = 5'd0).
REQ-014 exc_bd  out  1  BD flag to CP0.
REQ-015 hwint  out  6  synchronized, pending interrupt vector to CP0 Cause.IP.
REQ-016 eret_ack  out  1  one-cycle pulse clearing EXL in CP0.
REQ-017 flush  out  1  squash F/D/E/M pipeline registers.
REQ-018 redirect_valid  out  1  PC override valid.
REQ-019 redirect_pc  out  32  PC override target.
REQ-020 busy  out  1  FSM not IDLE.

Function
REQ-021 hwint_raw SHALL pass through SYNC_STAGES flops per bit; a synchronized high bit SHALL set a pending bit held until a TAKE of any interrupt or reset; hwint = pending bits.
REQ-022 int_req = sr_ie & ~sr_exl & |(hwint & sr_im); exc_req = sr_ie & ~sr_exl & (exc_code_m != 0).
REQ-023 Priority in IDLE: exc_req > int_req > eret_m; at most one accepted per cycle, lower ones ignored that cycle.
REQ-024 FSM states IDLE, TAKE, FLUSH, REDIRECT; encoding 2 bits.
REQ-025 IDLE->TAKE on exc_req or int_req; registers code (exc_code_m or 0), bd (exc_bd_m), target HANDLER_ADDR.
REQ-026 IDLE->FLUSH on eret_m alone; registers target = epc, asserts eret_ack in that same cycle of acceptance (combinational pulse, 1 cycle).
REQ-027 TAKE (1 cycle): exc_occur=1, exc_code/exc_bd = registered values, flush=1; next FLUSH; pending bits cleared at end of TAKE when code==0.
REQ-028 FLUSH (1 cycle): flush=1; next REDIRECT.
REQ-029 REDIRECT (1 cycle): redirect_valid=1, redirect_pc=registered target, flush=0; next IDLE.
REQ-030 Outside TAKE exc_occur=0, exc_code=0, exc_bd=0; outside REDIRECT redirect_valid=0, redirect_pc=0.
REQ-031 While busy, exc_code_m/eret_m SHALL be ignored (squashed instructions); interrupt pending bits SHALL keep accumulating.
REQ-032 Latency: request in IDLE at cycle N -> exc_occur at N+1, redirect_valid at N+3; ERET at N -> redirect_valid at N+2.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 reset SHALL force state IDLE, synchronizer and pending bits 0, registered code/bd/target 0; all outputs 0 the cycle after reset; reset mid-sequence aborts without exc_occur/redirect.
REQ-035 reset takes precedence over every request in the same cycle.

Structure
REQ-036 FSM state encodings, HANDLER_ADDR default and EXC_INT code (0) SHALL live in the shared macro header with the existing EXC_* codes.
REQ-037 One sub-module, int_sync (parameterized SYNC_STAGES, 6-bit synchronizer + pending latch), SHALL be instantiated; rest is flat.

Verification
REQ-038 exc_code_m=EXC_SYSCALL, sr_ie=1, sr_exl=0 -> exc_occur at N+1 with code EXC_SYSCALL, flush N+1..N+2, redirect_pc=32'h4180 at N+3.
REQ-039 hwint_raw[2] pulsed 1 cycle, sr_im=6'b000100, sr_ie=1 -> hwint=6'b000100 after 2 cycles, exc_occur code 0, pending cleared after TAKE.
REQ-040 Same cycle exc_code_m=EXC_SYSCALL, int pending, eret_m=1 -> exception taken, no eret_ack.
REQ-041 eret_m=1, epc=32'h3008 -> eret_ack same cycle, flush N+1, redirect_pc=32'h3008 at N+2.
REQ-042 sr_exl=1 with exc_code_m nonzero -> no exc_occur, busy stays 0; interrupt masked by sr_im=0 -> pending held, not taken until mask set.
REQ-043 reset asserted during FLUSH -> next cycle state IDLE, redirect_valid never asserts, hwint=0.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// Shared exception codes, sequencer state encoding and handler entry default
// for the exception/interrupt sequencer and its interrupt synchronizer.
package exc_sequencer_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam int          HWINT_W              = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TAKE     = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } seqState_t;

endpackage

// File: rtl/exc_sequencer_int_sync.sv
// Per-bit multi-flop synchronizer for the external interrupt lines, followed
// by a sticky pending latch that is cleared when an interrupt is taken.
module int_sync
  import exc_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [HWINT_W-1:0] hwintRaw,
  input  logic               clearPending,
  output logic [HWINT_W-1:0] hwint
);

  logic [HWINT_W-1:0] syncOut;
  logic [HWINT_W-1:0] pendingReg;

  generate
    for (genvar gi = 0; gi < HWINT_W; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chainReg;

      always_ff @(posedge clk) begin
        if (reset) begin
          chainReg <= '0;
        end else begin
          chainReg <= {chainReg[SYNC_STAGES-2:0], hwintRaw[gi]};
        end
      end

      assign syncOut[gi] = chainReg[SYNC_STAGES-1];
    end
  endgenerate

  // A line still asserted while the clear happens re-arms its pending bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingReg <= '0;
    end else begin
      pendingReg <= (clearPending ? '0 : pendingReg) | syncOut;
    end
  end

  assign hwint = pendingReg | syncOut;

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET sequencer: arbitrates requests at M stage, commits
// to CP0, flushes the pipeline and redirects the PC to the handler or EPC.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         exc_code_m,
  input  logic               exc_bd_m,
  input  logic               eret_m,
  input  logic [HWINT_W-1:0] hwint_raw,
  input  logic               sr_ie,
  input  logic               sr_exl,
  input  logic [HWINT_W-1:0] sr_im,
  input  logic [31:0]        epc,
  output logic               exc_occur,
  output logic [4:0]         exc_code,
  output logic               exc_bd,
  output logic [HWINT_W-1:0] hwint,
  output logic               eret_ack,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  seqState_t   stateReg;
  logic [31:0] targetReg;
  logic        excOccurReg;
  logic [4:0]  excCodeReg;
  logic        excBdReg;
  logic        flushReg;
  logic        redirValidReg;
  logic [31:0] redirPcReg;

  logic        intEnable;
  logic        excReq;
  logic        intReq;
  logic        eretTake;
  logic        clearPending;

  int_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk          (clk),
    .reset        (reset),
    .hwintRaw     (hwint_raw),
    .clearPending (clearPending),
    .hwint        (hwint)
  );

  assign intEnable = sr_ie & ~sr_exl;
  assign excReq    = intEnable & (exc_code_m != EXC_INT);
  assign intReq    = intEnable & (|(hwint & sr_im));

  // ERET wins only when nothing of higher priority is accepted this cycle.
  assign eretTake     = (stateReg == ST_IDLE) & eret_m & ~excReq & ~intReq & ~reset;
  assign clearPending = (stateReg == ST_TAKE) & (excCodeReg == EXC_INT);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= ST_IDLE;
      targetReg     <= '0;
      excOccurReg   <= 1'b0;
      excCodeReg    <= '0;
      excBdReg      <= 1'b0;
      flushReg      <= 1'b0;
      redirValidReg <= 1'b0;
      redirPcReg    <= '0;
    end else begin
      excOccurReg   <= 1'b0;
      excCodeReg    <= '0;
      excBdReg      <= 1'b0;
      flushReg      <= 1'b0;
      redirValidReg <= 1'b0;
      redirPcReg    <= '0;
      case (stateReg)
        ST_IDLE: begin
          if (excReq || intReq) begin
            stateReg    <= ST_TAKE;
            targetReg   <= HANDLER_ADDR;
            excOccurReg <= 1'b1;
            excCodeReg  <= excReq ? exc_code_m : EXC_INT;
            excBdReg    <= exc_bd_m;
            flushReg    <= 1'b1;
          end else if (eret_m) begin
            stateReg  <= ST_FLUSH;
            targetReg <= epc;
            flushReg  <= 1'b1;
          end
        end
        ST_TAKE: begin
          stateReg <= ST_FLUSH;
          flushReg <= 1'b1;
        end
        ST_FLUSH: begin
          stateReg      <= ST_REDIRECT;
          redirValidReg <= 1'b1;
          redirPcReg    <= targetReg;
        end
        ST_REDIRECT: begin
          stateReg <= ST_IDLE;
        end
        default: begin
          stateReg <= ST_IDLE;
        end
      endcase
    end
  end

  assign exc_occur      = excOccurReg;
  assign exc_code       = excCodeReg;
  assign exc_bd         = excBdReg;
  assign eret_ack       = eretTake;
  assign flush          = flushReg;
  assign redirect_valid = redirValidReg;
  assign redirect_pc    = redirPcReg;
  assign busy           = (stateReg != ST_IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomized bench for exc_sequencer against a cycle-timeline reference model.
module tb_exc_sequencer;

  localparam int          NCYC    = 2500;
  localparam int          SYNC    = 2;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic [4:0]  exc_code_m;
  logic        exc_bd_m;
  logic        eret_m;
  logic [5:0]  hwint_raw;
  logic        sr_ie;
  logic        sr_exl;
  logic [5:0]  sr_im;
  logic [31:0] epc;
  logic        exc_occur;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [5:0]  hwint;
  logic        eret_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  exc_sequencer #(
    .HANDLER_ADDR (HANDLER),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .exc_code_m     (exc_code_m),
    .exc_bd_m       (exc_bd_m),
    .eret_m         (eret_m),
    .hwint_raw      (hwint_raw),
    .sr_ie          (sr_ie),
    .sr_exl         (sr_exl),
    .sr_im          (sr_im),
    .epc            (epc),
    .exc_occur      (exc_occur),
    .exc_code       (exc_code),
    .exc_bd         (exc_bd),
    .hwint          (hwint),
    .eret_ack       (eret_ack),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  // Expected outputs per cycle, filled in when a request is accepted.
  bit        expOccur [0:NCYC+7];
  bit [4:0]  expCode  [0:NCYC+7];
  bit        expBd    [0:NCYC+7];
  bit        expFlush [0:NCYC+7];
  bit        expRv    [0:NCYC+7];
  bit [31:0] expPc    [0:NCYC+7];
  bit [5:0]  rawHist  [0:NCYC+7];

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, actual, expected);
    end
  endtask

  initial begin
    int  freeAt;
    int  clearFrom;
    int  pendClr;
    bit  idle, ie, excR, intR, erR;
    bit [5:0] hw;

    freeAt    = 0;
    clearFrom = 0;
    pendClr   = -1;
    reset      = 1'b1;
    exc_code_m = '0;
    exc_bd_m   = 1'b0;
    eret_m     = 1'b0;
    hwint_raw  = '0;
    sr_ie      = 1'b1;
    sr_exl     = 1'b0;
    sr_im      = 6'b111111;
    epc        = '0;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      reset      = (k < 3) || ($urandom_range(0, 79) == 0);
      exc_code_m = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      exc_bd_m   = 1'($urandom_range(0, 1));
      eret_m     = ($urandom_range(0, 5) == 0);
      hwint_raw  = ($urandom_range(0, 11) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      sr_ie      = ($urandom_range(0, 9) != 0);
      sr_exl     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) sr_im = 6'($urandom);
      epc        = $urandom & 32'hFFFF_FFFC;
      rawHist[k] = hwint_raw;

      @(negedge clk);
      cyc = k;

      if (k == pendClr) begin
        clearFrom = k - 1 - SYNC;
        pendClr   = -1;
      end
      // Pending vector = OR of every raw pulse old enough to be synchronized
      // since the last clear point.
      hw = '0;
      for (int j = (clearFrom < 0 ? 0 : clearFrom); j <= k - SYNC; j++) hw |= rawHist[j];

      if (reset) begin
        freeAt    = k + 1;
        clearFrom = k + 1;
        pendClr   = -1;
        for (int j = k + 1; j <= k + 4; j++) begin
          expOccur[j] = 0; expCode[j] = 0; expBd[j] = 0;
          expFlush[j] = 0; expRv[j] = 0; expPc[j] = 0;
        end
      end else begin
        idle = (k >= freeAt);
        ie   = sr_ie && !sr_exl;
        excR = idle && ie && (exc_code_m != 0);
        intR = idle && ie && ((hw & sr_im) != 0);
        erR  = idle && eret_m && !excR && !intR;

        checkVal("hwint",          32'(hwint),          32'(hw));
        checkVal("busy",           32'(busy),           32'(!idle));
        checkVal("exc_occur",      32'(exc_occur),      32'(expOccur[k]));
        checkVal("exc_code",       32'(exc_code),       32'(expCode[k]));
        checkVal("exc_bd",         32'(exc_bd),         32'(expBd[k]));
        checkVal("flush",          32'(flush),          32'(expFlush[k]));
        checkVal("redirect_valid", 32'(redirect_valid), 32'(expRv[k]));
        checkVal("redirect_pc",    redirect_pc,         expPc[k]);
        checkVal("eret_ack",       32'(eret_ack),       32'(erR));

        if (excR || intR) begin
          expOccur[k+1] = 1;
          expCode[k+1]  = excR ? exc_code_m : 5'd0;
          expBd[k+1]    = exc_bd_m;
          expFlush[k+1] = 1;
          expFlush[k+2] = 1;
          expRv[k+3]    = 1;
          expPc[k+3]    = HANDLER;
          freeAt        = k + 4;
          if (!excR) pendClr = k + 2;
          $display("cycle %0d: take %s code=%0d bd=%0d hwint=%b", k,
                   excR ? "exception" : "interrupt", excR ? exc_code_m : 5'd0, exc_bd_m, hw);
        end else if (erR) begin
          expFlush[k+1] = 1;
          expRv[k+2]    = 1;
          expPc[k+2]    = epc;
          freeAt        = k + 3;
          $display("cycle %0d: eret epc=%h", k, epc);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
